// File: rtl/packet_transmitter.sv
// Transmit-side framer and BPSK baseband modulator.
// Sends NUM_REF_REPEATS copies of REF_CODE as a sync preamble, then
// PAYLOAD_BITS payload bits fed byte-wise through a one-entry buffer.
// Each symbol is held for SAMPLES_PER_SYMBOL samples.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   S_IDLE     | outputs quiet, buffer may be preloaded, waits for start
//   S_PREAMBLE | reference code chips, MSB first, repeated
//   S_PAYLOAD  | payload bits, MSB first per byte, reloaded every 8 bits
//   S_DONE     | single cycle between frames, buffer closed
//
// The output register samples the modulator state one cycle late, so the
// frame appears one cycle after the state machine enters PREAMBLE and
// done appears one cycle after the machine enters DONE.
module packet_transmitter #(
   parameter int                          REFERENCE_LENGTH   = 15,
   parameter logic [REFERENCE_LENGTH-1:0] REF_CODE           = 15'b111101011001000,
   parameter int                          NUM_REF_REPEATS    = 2,
   parameter int                          PAYLOAD_BITS       = 224,
   parameter int                          SAMPLES_PER_SYMBOL = 4,
   parameter logic signed [7:0]           AMPLITUDE          = 8'sd100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic signed [7:0] mod_out,
   output logic              chip_out,
   output logic              symbol_clk,
   output logic              tx_active,
   output logic              underrun,
   output logic              done
);

   localparam int SPS      = SAMPLES_PER_SYMBOL;
   localparam int CNT_W    = (SPS > 2) ? $clog2(SPS) : 1;
   localparam int REF_W    = (REFERENCE_LENGTH > 2) ? $clog2(REFERENCE_LENGTH) : 1;
   localparam int SYM_W    = 9;
   localparam int PRE_SYMS = NUM_REF_REPEATS * REFERENCE_LENGTH;

   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SPS - 1);
   localparam logic [CNT_W-1:0] SAMPLE_HALF = CNT_W'(SPS / 2);
   localparam logic [REF_W-1:0] REF_LAST    = REF_W'(REFERENCE_LENGTH - 1);
   localparam logic [SYM_W-1:0] PRE_LAST    = SYM_W'(PRE_SYMS - 1);
   localparam logic [SYM_W-1:0] PAY_LAST    = SYM_W'(PAYLOAD_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PREAMBLE = 2'd1,
      S_PAYLOAD  = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
   logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
   logic [REF_W-1:0]  ref_idx_q, ref_idx_d;
   logic [7:0]        buf_q, buf_d;
   logic              buf_full_q, buf_full_d;
   logic [7:0]        shift_q, shift_d;
   logic              underrun_q, underrun_d;

   logic signed [7:0] mod_out_q, mod_out_d;
   logic              chip_q, chip_d;
   logic              sym_clk_q, sym_clk_d;
   logic              active_q, active_d;
   logic              done_q, done_d;
   logic              tx_ready_q, tx_ready_d;

   logic              sym_end;
   logic              pre_last;
   logic              pay_last;
   logic              accept;
   logic              load;
   logic [7:0]        load_byte;
   logic              chip_c;

   assign sym_end   = (sample_cnt_q == SAMPLE_LAST);
   assign pre_last  = (state_q == S_PREAMBLE) && sym_end && (sym_cnt_q == PRE_LAST);
   assign pay_last  = (state_q == S_PAYLOAD) && sym_end && (sym_cnt_q == PAY_LAST);
   assign accept    = tx_valid && tx_ready_q;
   // Byte boundary: first sample of every eighth payload bit.
   assign load      = (state_q == S_PAYLOAD) && (sample_cnt_q == '0) && (sym_cnt_q[2:0] == 3'd0);
   assign load_byte = buf_full_q ? buf_q : 8'h00;

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sample_cnt_q <= '0;
         sym_cnt_q    <= '0;
         ref_idx_q    <= '0;
         buf_q        <= 8'h00;
         buf_full_q   <= 1'b0;
         shift_q      <= 8'h00;
         underrun_q   <= 1'b0;
         mod_out_q    <= '0;
         chip_q       <= 1'b0;
         sym_clk_q    <= 1'b0;
         active_q     <= 1'b0;
         done_q       <= 1'b0;
         tx_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         sym_cnt_q    <= sym_cnt_d;
         ref_idx_q    <= ref_idx_d;
         buf_q        <= buf_d;
         buf_full_q   <= buf_full_d;
         shift_q      <= shift_d;
         underrun_q   <= underrun_d;
         mod_out_q    <= mod_out_d;
         chip_q       <= chip_d;
         sym_clk_q    <= sym_clk_d;
         active_q     <= active_d;
         done_q       <= done_d;
         tx_ready_q   <= tx_ready_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start)    state_d = S_PREAMBLE;
         S_PREAMBLE: if (pre_last) state_d = S_PAYLOAD;
         S_PAYLOAD:  if (pay_last) state_d = S_DONE;
         S_DONE:                   state_d = S_IDLE;
         default:                  state_d = S_IDLE;
      endcase
   end

   // Counters, byte buffer, payload shift register and underrun flag.
   always_comb begin
      sample_cnt_d = sample_cnt_q;
      sym_cnt_d    = sym_cnt_q;
      ref_idx_d    = ref_idx_q;
      buf_d        = buf_q;
      buf_full_d   = buf_full_q;
      shift_d      = shift_q;
      underrun_d   = underrun_q;

      if (state_d != state_q) begin
         sample_cnt_d = '0;
         sym_cnt_d    = '0;
         ref_idx_d    = '0;
      end else if (state_q == S_PREAMBLE || state_q == S_PAYLOAD) begin
         if (sym_end) begin
            sample_cnt_d = '0;
            sym_cnt_d    = sym_cnt_q + 1'b1;
            ref_idx_d    = (ref_idx_q == REF_LAST) ? '0 : ref_idx_q + 1'b1;
         end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
         end
      end

      if (load) begin
         shift_d    = load_byte;
         buf_full_d = 1'b0;
         if (!buf_full_q) underrun_d = 1'b1;
      end else if (state_q == S_PAYLOAD && sym_end) begin
         shift_d = {shift_q[6:0], 1'b0};
      end

      // An accept on a load cycle refills the buffer for the next byte.
      if (accept) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end

      if (state_q == S_IDLE && start) underrun_d = 1'b0;
   end

   // Output values, registered on the next edge.
   always_comb begin
      chip_c     = 1'b0;
      active_d   = 1'b0;
      case (state_q)
         S_PREAMBLE: begin
            chip_c   = REF_CODE[REF_LAST - ref_idx_q];
            active_d = 1'b1;
         end
         S_PAYLOAD: begin
            // On a load cycle the new byte is not in the shift register yet.
            chip_c   = load ? load_byte[7] : shift_q[7];
            active_d = 1'b1;
         end
         default: begin
            chip_c   = 1'b0;
            active_d = 1'b0;
         end
      endcase
      mod_out_d  = active_d ? (chip_c ? AMPLITUDE : -AMPLITUDE) : 8'sd0;
      chip_d     = active_d && chip_c;
      sym_clk_d  = active_d && (sample_cnt_q < SAMPLE_HALF);
      done_d     = (state_q == S_DONE);
      tx_ready_d = !buf_full_d && (state_d != S_DONE);
   end

   assign tx_ready   = tx_ready_q;
   assign mod_out    = mod_out_q;
   assign chip_out   = chip_q;
   assign symbol_clk = sym_clk_q;
   assign tx_active  = active_q;
   assign underrun   = underrun_q;
   assign done       = done_q;

endmodule

// File: tb/tb_packet_transmitter.sv
// Bench for packet_transmitter: two instances (4 and 2 samples per symbol),
// expected frames built from the framing rules with plain arithmetic.
module tb_packet_transmitter;

   localparam int NB       = 28;
   localparam int PRE_SYMS = 30;
   localparam int NSYM     = 254;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        rst_n_s    = 2'b00;
   logic [1:0]        start_s    = 2'b00;
   logic [1:0]        tx_valid_s = 2'b00;
   logic [7:0]        tx_data_s [2];
   logic [1:0]        tx_ready_s;
   logic [1:0]        chip_s;
   logic [1:0]        symclk_s;
   logic [1:0]        active_s;
   logic [1:0]        underrun_s;
   logic [1:0]        done_s;
   logic signed [7:0] mod0, mod1;

   packet_transmitter u_dut4 (
      .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]),
      .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]), .tx_ready(tx_ready_s[0]),
      .mod_out(mod0), .chip_out(chip_s[0]), .symbol_clk(symclk_s[0]),
      .tx_active(active_s[0]), .underrun(underrun_s[0]), .done(done_s[0])
   );

   packet_transmitter #(.SAMPLES_PER_SYMBOL(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]),
      .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]), .tx_ready(tx_ready_s[1]),
      .mod_out(mod1), .chip_out(chip_s[1]), .symbol_clk(symclk_s[1]),
      .tx_active(active_s[1]), .underrun(underrun_s[1]), .done(done_s[1])
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  pay [NB];
   logic [14:0] ref_code = 15'b111101011001000;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int mod_of(input int d);
      return d ? int'(mod1) : int'(mod0);
   endfunction

   // Symbol value of the frame: preamble chips, then payload MSB-first,
   // with bytes never supplied transmitted as zero.
   function automatic bit exp_chip(input int sym, input int nfeed);
      int b;
      if (sym < PRE_SYMS) return ref_code[14 - (sym % 15)];
      b = sym - PRE_SYMS;
      if (b / 8 < nfeed) return pay[b / 8][7 - (b % 8)];
      return 1'b0;
   endfunction

   task automatic run_frame(input int d, input int nfeed, input int ga, input int gb,
                            input int abort_at, input string name);
      int sps, flen, ptr, bad, bad_c, bad_obs, bad_exp, s, sym, ph, emod;
      bit hs, ec, aborted;
      sps = d ? 2 : 4;
      flen = NSYM * sps;
      ptr = 0; bad = 0; bad_c = 0; bad_obs = 0; bad_exp = 0; aborted = 0;

      if (nfeed > 0) begin
         tx_valid_s[d] = 1'b1;
         tx_data_s[d]  = pay[0];
         for (int i = 0; i < 10 && ptr == 0; i++) begin
            hs = tx_ready_s[d];
            @(posedge clk); #1;
            if (hs) ptr = 1;
         end
         check({name, "_preload"}, ptr, 1);
      end

      start_s[d]    = 1'b1;
      tx_valid_s[d] = (ptr < nfeed);
      tx_data_s[d]  = pay[(ptr < NB) ? ptr : 0];
      hs = tx_valid_s[d] && tx_ready_s[d];
      @(posedge clk); #1;
      if (hs) ptr++;
      start_s[d] = 1'b0;

      for (int c = 1; c <= flen + 1; c++) begin
         if (c == abort_at) rst_n_s[d] = 1'b0;
         start_s[d]    = (c == ga || c == gb);
         tx_valid_s[d] = (ptr < nfeed);
         tx_data_s[d]  = pay[(ptr < NB) ? ptr : 0];
         hs = tx_valid_s[d] && tx_ready_s[d];
         @(posedge clk); #1;
         if (hs) ptr++;
         if (c == abort_at) begin
            check({name, "_rst_mod"}, mod_of(d), 0);
            check({name, "_rst_active"}, int'(active_s[d]), 0);
            check({name, "_rst_ready"}, int'(tx_ready_s[d]), 0);
            check({name, "_rst_symclk"}, int'(symclk_s[d]), 0);
            aborted = 1;
            break;
         end
         if (c <= flen) begin
            s = c - 1;
            sym = s / sps;
            ph = s % sps;
            ec = exp_chip(sym, nfeed);
            emod = ec ? 100 : -100;
            if (mod_of(d) !== emod || chip_s[d] !== ec || symclk_s[d] !== (ph < sps / 2)
                || active_s[d] !== 1'b1 || done_s[d] !== 1'b0) begin
               if (bad == 0) begin
                  bad_c = c; bad_obs = mod_of(d); bad_exp = emod;
               end
               bad++;
            end
            if (c == PRE_SYMS * sps)
               check({name, "_underrun_pre"}, int'(underrun_s[d]), 0);
            if (c == PRE_SYMS * sps + 1)
               check({name, "_underrun_first_byte"}, int'(underrun_s[d]), (nfeed == 0) ? 1 : 0);
         end else begin
            check({name, "_done_pulse"}, int'(done_s[d]), 1);
            check({name, "_done_mod"}, mod_of(d), 0);
            check({name, "_done_active"}, int'(active_s[d]), 0);
         end
      end
      start_s[d] = 1'b0;

      n_tests++;
      assert (bad === 0) else begin
         n_fail++;
         $error("FAIL %s_samples observed=%0d bad samples (first at cycle %0d mod=%0d want %0d) expected=0",
                name, bad, bad_c, bad_obs, bad_exp);
      end

      if (!aborted) begin
         check({name, "_underrun_end"}, int'(underrun_s[d]), (nfeed == 0) ? 1 : 0);
         if (nfeed > 0) check({name, "_accepts"}, ptr, nfeed);
         tx_valid_s[d] = 1'b0;
         @(posedge clk); #1;
         check({name, "_done_cleared"}, int'(done_s[d]), 0);
         check({name, "_ready_idle"}, int'(tx_ready_s[d]), 1);
      end
      tx_valid_s[d] = 1'b0;
   endtask

   initial begin
      tx_data_s[0] = 8'h00;
      tx_data_s[1] = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", int'(tx_ready_s[0]), 0);
      check("reset_mod", int'(mod0), 0);
      check("reset_active", int'(active_s[0]), 0);
      check("reset_done", int'(done_s[0]), 0);
      check("reset_underrun", int'(underrun_s[0]), 0);
      check("reset_ready_sps2", int'(tx_ready_s[1]), 0);
      rst_n_s = 2'b11;
      @(posedge clk); #1;
      check("release_ready", int'(tx_ready_s[0]), 1);

      // Clean frame with 8'hA5 preloaded
      for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
      pay[0] = 8'hA5;
      run_frame(0, NB, 0, 0, 0, "clean");

      // No byte ever supplied
      run_frame(0, 0, 0, 0, 0, "nobytes");

      // start pulses mid-frame are ignored; same bytes as the clean run
      run_frame(0, NB, 5, 500, 0, "glitch");

      // Reset during the payload, then a fresh full frame
      for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
      run_frame(0, NB, 0, 0, 200, "reset_mid");
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold_ready", int'(tx_ready_s[0]), 0);
      check("reset_hold_underrun", int'(underrun_s[0]), 0);
      rst_n_s[0] = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
      run_frame(0, NB, 0, 0, 0, "after_reset");

      // Two samples per symbol, bytes offered continuously
      for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
      run_frame(1, NB, 0, 0, 0, "sps2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/packet_transmitter.md
# packet_transmitter

Transmit-side framer and BPSK baseband modulator for the acoustic modem. It emits two back-to-back copies of the reference code as a synchronization preamble, then a fixed-length payload. Every symbol is held for SAMPLES_PER_SYMBOL samples, so the far-end correlator and bit synchronizer see exactly the frame they expect. It sits between the packet source (byte stream) and the DAC/upconversion path.

## Interface
- REFERENCE_LENGTH, 15: chips per reference code.
- REF_CODE, 15'b111101011001000: reference m-sequence, sent MSB first.
- NUM_REF_REPEATS, 2: reference copies in the preamble.
- PAYLOAD_BITS, 224: payload symbols per packet; must be a multiple of 8.
- SAMPLES_PER_SYMBOL, 4: clk cycles per symbol; must be an even number ≥ 2.
- AMPLITUDE, 8'sd100: magnitude of the modulated output.

Ports:
- clk  in  1  sample clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a packet; sampled only in IDLE.
- tx_data  in  8  payload byte, MSB transmitted first.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  byte buffer empty; a transfer occurs on tx_valid && tx_ready.
- mod_out  out  signed 8  +AMPLITUDE for bit 1, -AMPLITUDE for bit 0, 0 when idle.
- chip_out  out  1  current symbol value; 0 when idle.
- symbol_clk  out  1  high for the first SAMPLES_PER_SYMBOL/2 cycles of each symbol; 0 when idle.
- tx_active  out  1  frame in progress.
- underrun  out  1  sticky; set when a payload byte was needed and the buffer was empty.
- done  out  1  one-cycle pulse after the last sample.

## Operation
- The FSM has four states: IDLE, PREAMBLE, PAYLOAD, DONE.
- **IDLE**
  - Outputs are zero.
  - tx_ready = 1, so a byte may be preloaded before start.
  - start = 1 → PREAMBLE. On entry: sample_cnt = 0, sym_cnt = 0, underrun cleared.
- **PREAMBLE**
  - Chip k (k = 0 .. NUM_REF_REPEATS*REFERENCE_LENGTH-1) is REF_CODE[REFERENCE_LENGTH-1 - (k mod REFERENCE_LENGTH)].
  - After the last sample of the last chip → PAYLOAD.
- **PAYLOAD**
  - At the start of each byte group (payload bit index mod 8 == 0), the shift register loads from the byte buffer, which then empties.
  - If the buffer is empty at that point, the shift register loads 8'h00 and underrun is set. Frame length never changes.
  - After the last sample of bit PAYLOAD_BITS-1 → DONE.
- **DONE**
  - done = 1 and tx_active = 0 for one cycle, then → IDLE.
- **Byte buffer**
  - One-entry buffer.
  - tx_ready = !buffer_full in all states except DONE, where tx_ready = 0.
  - A load into the shift register and a simultaneous tx_valid&&tx_ready accept in the same cycle is legal. The buffer ends that cycle full with the new byte.
- **Counters**
  - sample_cnt counts 0..SAMPLES_PER_SYMBOL-1 and wraps.
  - sym_cnt is 9 bits and counts symbols within the current state. It resets on each state change.
- start is ignored outside IDLE.
- tx_data is not captured outside tx_valid&&tx_ready.
- rst_n low at any time: the next edge forces IDLE, all outputs 0, buffer empty, underrun 0, and tx_ready = 0 while rst_n is low.

## Timing
- Every output is registered.
- start is sampled high at edge N. At edge N+1:
  - mod_out shows chip 0;
  - symbol_clk = 1;
  - tx_active = 1.
- Each symbol occupies exactly SAMPLES_PER_SYMBOL consecutive cycles. symbol_clk is high for the first half of them.
- Frame length is (NUM_REF_REPEATS*REFERENCE_LENGTH + PAYLOAD_BITS) * SAMPLES_PER_SYMBOL cycles. With the defaults this is 254 × 4 = 1016 cycles.
- done is asserted on the cycle immediately after the last frame sample, with mod_out = 0 in that cycle.
- The earliest next start is accepted in the cycle after done, i.e. in IDLE.
- The payload bit boundary is continuous: there is no gap between the last preamble chip and payload bit 0, or between bytes.
- A byte accepted on the same edge as a shift-register load counts as present for the following byte, not the current one.

## Test plan
- Preload 8'hA5, pulse start, and supply 27 more bytes promptly → mod_out shows +100 ×4 for chips 0–3 (1111), then 0 (−100 ×4), … REF_CODE twice. Payload begins at cycle 121 with 1,0,1,0,0,1,0,1. done pulses at cycle 1017. underrun = 0.
- No byte supplied for the whole packet → the payload is all −100, underrun = 1 after the first payload boundary, and done is still at cycle 1017.
- Pulse start again at cycles 5 and 500 mid-frame → no effect. The frame is identical to a clean run.
- Drive rst_n = 0 at cycle 200, with payload in progress → the next cycle has mod_out = 0, tx_active = 0, tx_ready = 0. After release, a fresh start produces a full correct frame.
- Set SAMPLES_PER_SYMBOL = 2 and hold tx_valid = 1 continuously → 508-cycle frame, and symbol_clk alternates 1,0 every cycle. No byte is lost: check 28 accept handshakes.
